pwm_multi: RTL and testbench

Multi-channel, parametrised PWM generator: the successor to the single 8-bit PWM block. One shared prescaler and period counter drive CHANNELS independent compare outputs. Each channel's duty is double-buffered, so software writes take effect only at a period boundary and never produce a glitched pulse. Sits between the register/control logic and the pad drivers (motor, LED and servo outputs).

---
 rtl/pwm_multi_if.sv | 17 +
 rtl/pwm_multi.sv | 63 ++++++
 tb/tb_pwm_multi.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/pwm_multi_if.sv
// pwm_multi_if: control, duty-write and output bundle for the multi-channel PWM.
interface pwm_multi_if #(
    parameter int WIDTH      = 8,
    parameter int CHANNELS   = 4,
    parameter int PRESCALE_W = 8
);
    localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
    logic                  en;
    logic [PRESCALE_W-1:0] prescale;
    logic                  wr_en;
    logic [CW-1:0]         wr_ch;
    logic [WIDTH-1:0]      wr_duty;
    logic [CHANNELS-1:0]   pwm_out;
    logic                  period_start;
    modport master(output en, prescale, wr_en, wr_ch, wr_duty, input pwm_out, period_start);
    modport slave(input en, prescale, wr_en, wr_ch, wr_duty, output pwm_out, period_start);
endinterface

// File: rtl/pwm_multi.sv
// pwm_multi: shared prescaler/counter driving CHANNELS double-buffered compare outputs.
// Define PWM_CENTER_ALIGN_EN for an up/down (center-aligned) counter instead of a sawtooth.
module pwm_multi #(
    parameter int WIDTH      = 8,
    parameter int CHANNELS   = 4,
    parameter int PRESCALE_W = 8
) (
    input logic       clk,
    input logic       rst,
    pwm_multi_if.slave bus_if
);
    localparam logic [WIDTH-1:0] MAX = '1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    logic [PRESCALE_W-1:0] psc_q;
    logic [WIDTH-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]      shadow_q [CHANNELS];
    logic [WIDTH-1:0]      active_q [CHANNELS];
    logic [CHANNELS-1:0]   pwm_q, pwm_d;
    logic                  ps_q, en_q, tick, wrap;

    assign tick = bus_if.en && psc_q >= bus_if.prescale;

`ifdef PWM_CENTER_ALIGN_EN
    logic down_q, down_d;
    // Boundary is the downward tick that lands back on zero.
    assign wrap   = tick && down_q && cnt_q == ONE;
    assign cnt_d  = !tick ? cnt_q : (down_q || cnt_q == MAX) ? cnt_q - ONE : cnt_q + ONE;
    assign down_d = !tick ? down_q : down_q ? cnt_q != ONE : cnt_q == MAX;
    always_ff @(posedge clk) down_q <= !rst && bus_if.en && down_d;
`else
    assign wrap  = tick && cnt_q == MAX;
    assign cnt_d = tick ? cnt_q + ONE : cnt_q;
`endif

    always_comb begin
        pwm_d = '0;
        for (int i = 0; i < CHANNELS; i++) pwm_d[i] = active_q[i] == MAX || cnt_q < active_q[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            psc_q    <= '0;
            cnt_q    <= '0;
            pwm_q    <= '0;
            ps_q     <= 1'b0;
            en_q     <= 1'b0;
            shadow_q <= '{default: '0};
            active_q <= '{default: '0};
        end else begin
            en_q  <= bus_if.en;
            psc_q <= (!bus_if.en || tick) ? '0 : psc_q + 1'b1;
            cnt_q <= bus_if.en ? cnt_d : '0;
            pwm_q <= bus_if.en ? pwm_d : '0;
            ps_q  <= bus_if.en && (wrap || !en_q);
            // While disabled active tracks shadow so the first enabled period uses the latest writes.
            if (!bus_if.en || wrap) active_q <= shadow_q;
            if (bus_if.wr_en && 32'(bus_if.wr_ch) < CHANNELS) shadow_q[bus_if.wr_ch] <= bus_if.wr_duty;
        end
    end

    assign bus_if.pwm_out      = pwm_q;
    assign bus_if.period_start = ps_q;
endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: randomized and directed checks of pwm_multi against a tick-position reference model.
module tb_pwm_multi;
    localparam int W = 8;
    localparam int N = 4;
    localparam int TOP = (1 << W) - 1;
`ifdef PWM_CENTER_ALIGN_EN
    localparam int PER = 2 * TOP;
`else
    localparam int PER = TOP + 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_cmp = 0;
    int n_err = 0;

    pwm_multi_if #(.WIDTH(W), .CHANNELS(N), .PRESCALE_W(8)) b ();
    pwm_multi #(.WIDTH(W), .CHANNELS(N), .PRESCALE_W(8)) dut (.clk(clk), .rst(rst), .bus_if(b));

    always #5 clk = ~clk;

    // Reference: counter position derived from the number of ticks since enable.
    int m_ticks, m_psc;
    int m_sh [N];
    int m_act [N];
    logic m_pen;
    logic [N-1:0] exp_pwm;
    logic exp_ps;

    function automatic int m_cnt();
        int p = m_ticks % PER;
        return p <= TOP ? p : PER - p;
    endfunction

    function automatic int exp_high(input int d, input int pre);
`ifdef PWM_CENTER_ALIGN_EN
        return (d == TOP ? PER : d == 0 ? 0 : 2 * d - 1) * (pre + 1);
`else
        return (d == TOP ? PER : d) * (pre + 1);
`endif
    endfunction

    always @(posedge clk) begin
        logic tk, bd;
        if (rst) begin
            m_ticks = 0; m_psc = 0; m_pen = 1'b0; exp_pwm = '0; exp_ps = 1'b0;
            for (int i = 0; i < N; i++) begin m_sh[i] = 0; m_act[i] = 0; end
        end else begin
            for (int i = 0; i < N; i++) exp_pwm[i] = b.en && (m_act[i] == TOP || m_cnt() < m_act[i]);
            tk = b.en && m_psc >= int'(b.prescale);
            bd = tk && (m_ticks + 1) % PER == 0;
            exp_ps = b.en && (!m_pen || bd);
            if (!b.en || bd) m_act = m_sh;
            if (b.wr_en) m_sh[b.wr_ch] = int'(b.wr_duty);
            m_psc = (!b.en || tk) ? 0 : m_psc + 1;
            m_ticks = b.en ? m_ticks + int'(tk) : 0;
            m_pen = b.en;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        chk("pwm_out", 32'(b.pwm_out), 32'(exp_pwm));
        chk("period_start", 32'(b.period_start), 32'(exp_ps));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wr(input int ch, input int d);
        b.wr_en = 1'b1; b.wr_ch = 2'(ch); b.wr_duty = 8'(d);
        cyc();
        b.wr_en = 1'b0;
    endtask

    task automatic measure(input int ch, output int hi, output int len);
        int k = 0;
        hi = 0; len = 0;
        while (!b.period_start && k < 5000) begin cyc(); k++; end
        do begin
            if (b.pwm_out[ch]) hi++;
            len++;
            cyc();
        end while (!b.period_start && len < 5000);
    endtask

    task automatic wait_for(input int mode, input int v);
        int k = 0;
        while (k < 3000 && !(mode == 0 ? m_cnt() == v && m_psc == 0 :
                             mode == 1 ? b.en && m_psc >= int'(b.prescale) && (m_ticks + 1) % PER == 0 :
                             m_psc == v)) begin cyc(); k++; end
        chk("wait_bound", 32'(k < 3000), 32'd1);
    endtask

    initial begin
        int hi, len;
        b.en = 1'b1; b.prescale = '0; b.wr_en = 1'b0; b.wr_ch = '0; b.wr_duty = '0;
        @(negedge clk);
        // Reset held 3 clocks with writes pending; everything stays low.
        wr(0, 77); wr(1, 200);
        cyc();
        chk("rst_pwm", 32'(b.pwm_out), 32'd0);
        chk("rst_ps", 32'(b.period_start), 32'd0);
        rst = 1'b0;
        run(2 * PER + 10);
        chk("post_rst_low", 32'(b.pwm_out), 32'd0);

        // Basic duty loaded while disabled.
        b.en = 1'b0;
        wr(0, 20); wr(2, 200);
        b.en = 1'b1;
        cyc();
        chk("enable_ps", 32'(b.period_start), 32'd1);
        cyc();
        measure(0, hi, len);
        chk("ch0_hi", 32'(hi), 32'(exp_high(20, 0)));
        chk("period_len", 32'(len), 32'(PER));
        measure(2, hi, len);
        chk("ch2_hi", 32'(hi), 32'(exp_high(200, 0)));

        // Extremes.
        wr(1, TOP);
        measure(1, hi, len);
        for (int p = 0; p < 3; p++) begin
            measure(1, hi, len);
            chk("ch1_full", 32'(hi), 32'(len));
        end
        wr(1, 0);
        measure(1, hi, len);
        for (int p = 0; p < 3; p++) begin
            measure(1, hi, len);
            chk("ch1_zero", 32'(hi), 32'd0);
        end

        // Double buffering: mid-period write, then a write on the boundary edge.
        wait_for(0, 50);
        wr(0, 100);
        measure(0, hi, len);
        chk("dbuf_mid", 32'(hi), 32'(exp_high(100, 0)));
        wait_for(1, 0);
        wr(0, 60);
        measure(0, hi, len);
        chk("dbuf_edge_old", 32'(hi), 32'(exp_high(100, 0)));
        measure(0, hi, len);
        chk("dbuf_edge_new", 32'(hi), 32'(exp_high(60, 0)));

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(7) == 0) begin
                b.wr_en = 1'b1; b.wr_ch = 2'($urandom_range(N - 1));
                b.wr_duty = $urandom_range(3) == 0 ? ($urandom_range(1) == 0 ? 8'd0 : 8'hff) : 8'($urandom);
            end else b.wr_en = 1'b0;
            if ($urandom_range(299) == 0) b.en = ~b.en;
            if ($urandom_range(499) == 0) b.prescale = 8'($urandom_range(2));
            cyc();
        end
        b.wr_en = 1'b0;

        // Prescale 3 with a half-scale duty.
        b.en = 1'b1; b.prescale = 8'd3;
        wr(3, 128);
        measure(3, hi, len);
        measure(3, hi, len);
        chk("pre_period", 32'(len), 32'(PER * 4));
        chk("pre_hi", 32'(hi), 32'(exp_high(128, 3)));
        wait_for(2, 1);
        b.prescale = 8'd0;
        run(2 * PER);

        // Reset for 100 clocks mid-period.
        wait_for(0, 100);
        rst = 1'b1;
        cyc();
        chk("midrst_low", 32'(b.pwm_out), 32'd0);
        run(99);
        rst = 1'b0;
        run(2 * PER + 5);
        chk("after_rst_low", 32'(b.pwm_out), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
